// File: rtl/ula_op_sequencer_if.sv
// Command, ULA and result channels of the ULA issue sequencer.
// master = upstream/consumer side, slave = the sequencer itself.
interface ula_op_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_acc;
    logic             acc_clr;
    logic [1:0]       alu_sel;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_s;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_zero;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] op_count;

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_acc, acc_clr, alu_s, res_ready,
        output in_ready, alu_sel, alu_a, alu_b, res_valid, res_data, res_zero,
               acc, op_count
    );

    modport master (
        output in_valid, in_op, in_a, in_b, in_acc, acc_clr, alu_s, res_ready,
        input  in_ready, alu_sel, alu_a, alu_b, res_valid, res_data, res_zero,
               acc, op_count
    );
endinterface

// File: rtl/ula_op_sequencer.sv
// Issue stage for the 4-function ULA: registers one command onto the ULA inputs,
// captures the ULA output a cycle later, and holds it until the consumer takes it.
module ula_op_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    ula_op_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       alu_sel_q, alu_sel_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             res_valid_q, res_valid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            alu_sel_q   <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            res_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_sel_q   <= alu_sel_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            res_q       <= res_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            res_valid_q <= res_valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        alu_sel_d = alu_sel_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        res_d     = res_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    alu_sel_d = bus.in_op;
                    // acc_q here is the pre-clear value even if acc_clr is also high
                    alu_a_d   = bus.in_acc ? acc_q : bus.in_a;
                    alu_b_d   = bus.in_b;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                res_d   = bus.alu_s;
                acc_d   = bus.alu_s;
                state_d = DONE;
            end
            DONE: begin
                if (bus.res_ready) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear overrides the EXEC capture into acc but not into res
        if (bus.acc_clr) acc_d = '0;

        // Handshake flags are registered copies of the next state
        in_ready_d  = (state_d == IDLE);
        res_valid_d = (state_d == DONE);
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.alu_sel   = alu_sel_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.res_data  = res_q;
    assign bus.res_zero  = (res_q == '0);
    assign bus.acc       = acc_q;
    assign bus.op_count  = cnt_q;

    a_flags_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(in_ready_q && res_valid_q));
    a_ready_state: assert property (@(posedge clk) disable iff (!rst_n)
        in_ready_q == (state_q == IDLE));
    a_valid_state: assert property (@(posedge clk) disable iff (!rst_n)
        res_valid_q == (state_q == DONE));

endmodule

// File: tb/tb_ula_op_sequencer.sv
// Randomized and directed bench for ula_op_sequencer against an arithmetic reference model.
module tb_ula_op_sequencer;
    localparam int W   = 4;
    localparam int C   = 8;
    localparam int MOD = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    int   m_acc = 0;
    int   m_cnt = 0;

    always #5 clk = ~clk;

    ula_op_sequencer_if #(.WIDTH(W), .CNT_W(C)) ifc ();

    ula_op_sequencer #(.WIDTH(W), .CNT_W(C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    // Combinational ULA stand-in driven by the sequencer outputs
    always_comb begin
        ifc.alu_s = '0;
        case (ifc.alu_sel)
            2'd0: ifc.alu_s = ifc.alu_a + ifc.alu_b;
            2'd1: ifc.alu_s = ifc.alu_a - ifc.alu_b;
            2'd2: ifc.alu_s = ifc.alu_a >> ifc.alu_b;
            2'd3: ifc.alu_s = ifc.alu_a << ifc.alu_b;
            default: ifc.alu_s = '0;
        endcase
    end

    function automatic int ref_ula(input int op, input int a, input int b);
        case (op)
            0: return (a + b) % MOD;
            1: return (a - b + MOD) % MOD;
            2: return (b >= W) ? 0 : a / (2 ** b);
            default: return (b >= W) ? 0 : (a * (2 ** b)) % MOD;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for in_ready, then presents the command for exactly one edge
    task automatic send_cmd(input int op, input int a, input int b, input bit use_acc, input bit clr);
        int n = 0;
        while (ifc.in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (ifc.in_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL handshake_timeout in_ready=%0b required=1", ifc.in_ready);
        end
        ifc.in_op    = 2'(op);
        ifc.in_a     = W'(a);
        ifc.in_b     = W'(b);
        ifc.in_acc   = use_acc;
        ifc.acc_clr  = clr;
        ifc.in_valid = 1'b1;
        tick();
        ifc.in_valid = 1'b0;
        ifc.acc_clr  = 1'b0;
        ifc.in_acc   = 1'b0;
    endtask

    task automatic consume();
        ifc.res_ready = 1'b1;
        tick();
        ifc.res_ready = 1'b0;
        m_cnt = (m_cnt + 1) % (2 ** C);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifc.in_valid = 0; ifc.in_op = 0; ifc.in_a = 0; ifc.in_b = 0;
        ifc.in_acc = 0; ifc.acc_clr = 0; ifc.res_ready = 0;
        #12;
        checks++;
        if (ifc.res_valid !== 1'b0 || ifc.alu_sel !== 2'd0 || ifc.alu_a !== 4'd0 ||
            ifc.alu_b !== 4'd0 || ifc.res_data !== 4'd0 || ifc.acc !== 4'd0 ||
            ifc.op_count !== 8'd0 || ifc.res_zero !== 1'b1) begin
            failures++;
            $display("FAIL reset_values got valid=%0b sel=%0d a=%0d b=%0d res=%0d acc=%0d cnt=%0d zero=%0b required 0,0,0,0,0,0,0,1",
                     ifc.res_valid, ifc.alu_sel, ifc.alu_a, ifc.alu_b, ifc.res_data, ifc.acc,
                     ifc.op_count, ifc.res_zero);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (ifc.in_ready !== 1'b1 || ifc.res_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release in_ready=%0b res_valid=%0b required 1,0", ifc.in_ready, ifc.res_valid);
        end
    endtask

    task automatic test_basic();
        send_cmd(0, 7, 5, 0, 0);
        checks++;
        if (ifc.alu_a !== 4'd7 || ifc.alu_b !== 4'd5 || ifc.alu_sel !== 2'd0 ||
            ifc.in_ready !== 1'b0 || ifc.res_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_issue a=%0d b=%0d sel=%0d rdy=%0b vld=%0b required 7,5,0,0,0",
                     ifc.alu_a, ifc.alu_b, ifc.alu_sel, ifc.in_ready, ifc.res_valid);
        end
        tick();
        m_acc = 12;
        checks++;
        if (ifc.res_valid !== 1'b1 || ifc.res_data !== 4'd12 || ifc.res_zero !== 1'b0 || ifc.acc !== 4'd12) begin
            failures++;
            $display("FAIL basic_result vld=%0b res=%0d zero=%0b acc=%0d required 1,12,0,12",
                     ifc.res_valid, ifc.res_data, ifc.res_zero, ifc.acc);
        end
        consume();
        checks++;
        if (ifc.op_count !== 8'd1 || ifc.in_ready !== 1'b1 || ifc.res_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_consume cnt=%0d rdy=%0b vld=%0b required 1,1,0", ifc.op_count, ifc.in_ready, ifc.res_valid);
        end
    endtask

    task automatic test_chain();
        send_cmd(1, 9, 12, 1, 0);
        checks++;
        if (ifc.alu_a !== 4'd12) begin
            failures++;
            $display("FAIL chain_alu_a got=%0d required=12", ifc.alu_a);
        end
        tick();
        m_acc = 0;
        checks++;
        if (ifc.res_data !== 4'd0 || ifc.res_zero !== 1'b1 || ifc.acc !== 4'd0) begin
            failures++;
            $display("FAIL chain_result res=%0d zero=%0b acc=%0d required 0,1,0", ifc.res_data, ifc.res_zero, ifc.acc);
        end
        consume();
        checks++;
        if (ifc.op_count !== 8'd2) begin
            failures++;
            $display("FAIL chain_count got=%0d required=2", ifc.op_count);
        end
    endtask

    task automatic test_wrap_shifts();
        int tbl [4][4] = '{'{0, 15, 1, 0}, '{2, 8, 3, 1}, '{3, 1, 4, 0}, '{1, 3, 5, 14}};
        for (int i = 0; i < 4; i++) begin
            send_cmd(tbl[i][0], tbl[i][1], tbl[i][2], 0, 0);
            tick();
            m_acc = tbl[i][3];
            checks++;
            if (ifc.res_data !== 4'(tbl[i][3]) || ifc.res_zero !== (tbl[i][3] == 0) || ifc.acc !== 4'(tbl[i][3])) begin
                failures++;
                $display("FAIL wrap_shift_%0d res=%0d zero=%0b acc=%0d required res=%0d", i,
                         ifc.res_data, ifc.res_zero, ifc.acc, tbl[i][3]);
            end
            consume();
        end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        send_cmd(0, 2, 3, 0, 0);
        tick();
        m_acc = 5;
        ifc.in_valid = 1'b1; ifc.in_op = 2'd3; ifc.in_a = 4'd9; ifc.in_b = 4'd1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ifc.res_valid !== 1'b1 || ifc.res_data !== 4'd5 || ifc.in_ready !== 1'b0 ||
                ifc.alu_a !== 4'd2 || ifc.alu_sel !== 2'd0)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL backpressure_hold bad_cycles=%0d required=0 (last vld=%0b res=%0d rdy=%0b a=%0d)",
                     bad, ifc.res_valid, ifc.res_data, ifc.in_ready, ifc.alu_a);
        end
        ifc.in_valid = 1'b0;
        consume();
        checks++;
        if (ifc.in_ready !== 1'b1 || ifc.res_valid !== 1'b0 || ifc.op_count !== 8'(m_cnt)) begin
            failures++;
            $display("FAIL backpressure_release rdy=%0b vld=%0b cnt=%0d required 1,0,%0d",
                     ifc.in_ready, ifc.res_valid, ifc.op_count, m_cnt);
        end
    endtask

    task automatic test_acc_clr();
        send_cmd(0, 6, 3, 0, 0);
        ifc.acc_clr = 1'b1;
        tick();
        ifc.acc_clr = 1'b0;
        m_acc = 0;
        checks++;
        if (ifc.res_data !== 4'd9 || ifc.acc !== 4'd0) begin
            failures++;
            $display("FAIL clr_in_exec res=%0d acc=%0d required 9,0", ifc.res_data, ifc.acc);
        end
        consume();
        send_cmd(0, 11, 2, 1, 0);
        tick();
        m_acc = 2;
        checks++;
        if (ifc.res_data !== 4'd2 || ifc.acc !== 4'd2) begin
            failures++;
            $display("FAIL clr_then_acc res=%0d acc=%0d required 2,2", ifc.res_data, ifc.acc);
        end
        consume();
        // Clear on the issuing edge: ULA still sees the pre-clear accumulator
        send_cmd(0, 0, 1, 1, 1);
        checks++;
        if (ifc.alu_a !== 4'd2 || ifc.acc !== 4'd0) begin
            failures++;
            $display("FAIL clr_at_issue alu_a=%0d acc=%0d required 2,0", ifc.alu_a, ifc.acc);
        end
        tick();
        m_acc = 3;
        consume();
    endtask

    task automatic test_random();
        int op, a, b, ea, exp, hold;
        bit use_acc, clr_hs, clr_ex;
        for (int i = 0; i < 30; i++) begin
            op = $urandom_range(0, 3);
            a = $urandom_range(0, MOD - 1);
            b = $urandom_range(0, MOD - 1);
            use_acc = 1'($urandom_range(0, 1));
            clr_hs = ($urandom_range(0, 3) == 0);
            clr_ex = ($urandom_range(0, 3) == 0);
            hold = $urandom_range(0, 3);
            ea = use_acc ? m_acc : a;
            exp = ref_ula(op, ea, b);
            send_cmd(op, a, b, use_acc, clr_hs);
            checks++;
            if (ifc.alu_a !== 4'(ea) || ifc.alu_b !== 4'(b) || ifc.alu_sel !== 2'(op)) begin
                failures++;
                $display("FAIL rand_issue_%0d a=%0d b=%0d sel=%0d required %0d,%0d,%0d", i,
                         ifc.alu_a, ifc.alu_b, ifc.alu_sel, ea, b, op);
            end
            ifc.acc_clr = clr_ex;
            tick();
            ifc.acc_clr = 1'b0;
            m_acc = clr_ex ? 0 : exp;
            for (int h = 0; h < hold; h++) tick();
            checks++;
            if (ifc.res_valid !== 1'b1 || ifc.res_data !== 4'(exp) || ifc.res_zero !== (exp == 0) ||
                ifc.acc !== 4'(m_acc)) begin
                failures++;
                $display("FAIL rand_result_%0d vld=%0b res=%0d zero=%0b acc=%0d required 1,%0d,%0b,%0d", i,
                         ifc.res_valid, ifc.res_data, ifc.res_zero, ifc.acc, exp, exp == 0, m_acc);
            end
            consume();
            checks++;
            if (ifc.op_count !== 8'(m_cnt)) begin
                failures++;
                $display("FAIL rand_count_%0d got=%0d required=%0d", i, ifc.op_count, m_cnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        send_cmd(0, 3, 4, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        m_acc = 0;
        m_cnt = 0;
        checks++;
        if (ifc.res_valid !== 1'b0 || ifc.alu_a !== 4'd0 || ifc.alu_b !== 4'd0 || ifc.res_data !== 4'd0 ||
            ifc.acc !== 4'd0 || ifc.op_count !== 8'd0 || ifc.res_zero !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_clear vld=%0b a=%0d b=%0d res=%0d acc=%0d cnt=%0d zero=%0b required 0,0,0,0,0,0,1",
                     ifc.res_valid, ifc.alu_a, ifc.alu_b, ifc.res_data, ifc.acc, ifc.op_count, ifc.res_zero);
        end
        #3;
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (ifc.res_valid !== 1'b0 || ifc.op_count !== 8'd0 || ifc.in_ready !== 1'b1 || ifc.acc !== 4'd0) begin
            failures++;
            $display("FAIL reset_mid_after vld=%0b cnt=%0d rdy=%0b acc=%0d required 0,0,1,0",
                     ifc.res_valid, ifc.op_count, ifc.in_ready, ifc.acc);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_chain();
        test_wrap_shifts();
        test_backpressure();
        test_acc_clr();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout time=%0t limit=200000", $time);
        $fatal(1, "bench timeout");
    end
endmodule
